// File: rtl/elevator_request_queue_pkg.sv
// Shared types for the elevator controller: floor numbers, travel direction codes and
// the request-queue presentation states.
package elevator_pkg;

    typedef logic [3:0] floor_t;

    localparam logic [1:0] GOING_UP   = 2'b11;
    localparam logic [1:0] GOING_DOWN = 2'b00;
    localparam logic [1:0] STATIONARY = 2'b01;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } queue_state_t;

    // Signed compare keeps the check well-formed when the lower bound is 0.
    function automatic logic floor_in_range(floor_t f, int lo, int hi);
        return (int'(f) >= lo) && (int'(f) < hi);
    endfunction

endpackage

// File: rtl/elevator_request_queue_if.sv
// Call intake and head-presentation signals between the panel scanner, the request
// queue and ElevatorLogic.
interface elevator_request_queue_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic                call_valid_i;
    logic                call_ready_o;
    elevator_pkg::floor_t call_src_floor_i;
    elevator_pkg::floor_t call_dst_floor_i;
    logic                call_drop_o;
    logic                request_o;
    elevator_pkg::floor_t requested_current_floor_o;
    elevator_pkg::floor_t requested_destination_floor_o;
    logic                request_served_i;
    logic [CntW-1:0]     count_o;
    logic                stall_o;

    modport slave (
        input  call_valid_i, call_src_floor_i, call_dst_floor_i, request_served_i,
        output call_ready_o, call_drop_o, request_o, requested_current_floor_o,
               requested_destination_floor_o, count_o, stall_o
    );

    modport master (
        output call_valid_i, call_src_floor_i, call_dst_floor_i, request_served_i,
        input  call_ready_o, call_drop_o, request_o, requested_current_floor_o,
               requested_destination_floor_o, count_o, stall_o
    );

endinterface

// File: rtl/elevator_request_queue_request_fifo.sv
// Circular call buffer with a per-entry valid mask and a parallel (src, dst) duplicate
// comparator across all occupied entries.
module request_fifo
    import elevator_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned PtrW  = $clog2(DEPTH),
    localparam int unsigned CntW  = PtrW + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  floor_t          src_i,
    input  floor_t          dst_i,
    output floor_t          head_src_o,
    output floor_t          head_dst_o,
    output logic [CntW-1:0] count_o,
    output logic            dup_hit_o
);

    floor_t             src_q [DEPTH];
    floor_t             dst_q [DEPTH];
    logic [DEPTH-1:0]   valid_q;
    logic [PtrW-1:0]    head_q, tail_q;
    logic [CntW-1:0]    count_q;

    always_comb begin
        dup_hit_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && src_q[i] == src_i && dst_q[i] == dst_i) dup_hit_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                src_q[i] <= '0;
                dst_q[i] <= '0;
            end
        end else begin
            if (pop_i) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PtrW'(1);
            end
            if (push_i) begin
                src_q[tail_q]   <= src_i;
                dst_q[tail_q]   <= dst_i;
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PtrW'(1);
            end
            count_q <= count_q + CntW'(push_i) - CntW'(pop_i);
        end
    end

    assign head_src_o = src_q[head_q];
    assign head_dst_o = dst_q[head_q];
    assign count_o    = count_q;

endmodule

// File: rtl/elevator_request_queue.sv
// Hall-call queue: validates and de-duplicates panel calls, buffers them, and presents the
// oldest one to ElevatorLogic until served, with a watchdog for calls left unserved.
module elevator_request_queue
    import elevator_pkg::*;
#(
    parameter  int unsigned DEPTH     = 8,
    parameter  int          MAXFLOORS = 10,
    parameter  int          MINFLOORS = 0,
    parameter  int unsigned TIMEOUT   = 255,
    localparam int unsigned CntW      = $clog2(DEPTH) + 1
) (
    input logic                    clk_i,
    input logic                    rst_i,
    elevator_request_queue_if.slave bus
);

    queue_state_t    state_q, state_d;
    logic            request_q, request_d;
    floor_t          cur_q, cur_d, dst_q, dst_d;
    logic [15:0]     wd_q, wd_d;
    logic            drop_q;
    logic [CntW-1:0] count;
    floor_t          head_src, head_dst;
    logic            dup_hit, handshake, bad_call, push, pop;

    assign bus.call_ready_o = (count != CntW'(DEPTH));
    assign handshake        = bus.call_valid_i && bus.call_ready_o;
    assign bad_call         = (bus.call_src_floor_i == bus.call_dst_floor_i)
                           || !floor_in_range(bus.call_src_floor_i, MINFLOORS, MAXFLOORS)
                           || !floor_in_range(bus.call_dst_floor_i, MINFLOORS, MAXFLOORS);
    assign push             = handshake && !bad_call && !dup_hit;

    request_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (push),
        .pop_i      (pop),
        .src_i      (bus.call_src_floor_i),
        .dst_i      (bus.call_dst_floor_i),
        .head_src_o (head_src),
        .head_dst_o (head_dst),
        .count_o    (count),
        .dup_hit_o  (dup_hit)
    );

    always_comb begin
        state_d   = state_q;
        request_d = request_q;
        cur_d     = cur_q;
        dst_d     = dst_q;
        wd_d      = wd_q;
        pop       = 1'b0;
        unique case (state_q)
            IDLE, GAP: begin
                // In GAP the count already reflects the pop on the previous edge.
                if (count != '0) begin
                    state_d   = PRESENT;
                    request_d = 1'b1;
                    cur_d     = head_src;
                    dst_d     = head_dst;
                    wd_d      = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            PRESENT: begin
                if (bus.request_served_i) begin
                    pop       = 1'b1;
                    state_d   = GAP;
                    request_d = 1'b0;
                    wd_d      = '0;
                end else if (wd_q != 16'(TIMEOUT)) begin
                    wd_d = wd_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            request_q <= 1'b0;
            cur_q     <= '0;
            dst_q     <= '0;
            wd_q      <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            request_q <= request_d;
            cur_q     <= cur_d;
            dst_q     <= dst_d;
            wd_q      <= wd_d;
            drop_q    <= handshake && (bad_call || dup_hit);
        end
    end

    assign bus.request_o                     = request_q;
    assign bus.requested_current_floor_o     = cur_q;
    assign bus.requested_destination_floor_o = dst_q;
    assign bus.call_drop_o                   = drop_q;
    assign bus.count_o                       = count;
    assign bus.stall_o                       = (wd_q == 16'(TIMEOUT));

endmodule

// File: tb/tb_elevator_request_queue.sv
// Directed bench for elevator_request_queue: intake validation, ordering, full/wrap,
// watchdog and mid-operation reset.
module tb_elevator_request_queue;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    elevator_request_queue_if #(.DEPTH(8)) bus ();

    elevator_request_queue #(
        .DEPTH     (8),
        .MAXFLOORS (10),
        .MINFLOORS (0),
        .TIMEOUT   (20)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic push(input logic [3:0] s, input logic [3:0] d);
        bus.call_valid_i     = 1'b1;
        bus.call_src_floor_i = s;
        bus.call_dst_floor_i = d;
        step();
        bus.call_valid_i = 1'b0;
    endtask

    task automatic serve();
        bus.request_served_i = 1'b1;
        step();
        bus.request_served_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".request"}, 16'(bus.request_o), 16'd0);
        check({tag, ".cur"}, 16'(bus.requested_current_floor_o), 16'd0);
        check({tag, ".dst"}, 16'(bus.requested_destination_floor_o), 16'd0);
        check({tag, ".count"}, 16'(bus.count_o), 16'd0);
        check({tag, ".ready"}, 16'(bus.call_ready_o), 16'd1);
        check({tag, ".drop"}, 16'(bus.call_drop_o), 16'd0);
        check({tag, ".stall"}, 16'(bus.stall_o), 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        logic [3:0] exp_src [8];
        logic [3:0] exp_dst [8];

        bus.call_valid_i     = 1'b0;
        bus.call_src_floor_i = '0;
        bus.call_dst_floor_i = '0;
        bus.request_served_i = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_reset_outputs("reset");

        // Single call through an empty queue.
        push(4'd3, 4'd7);
        check("t1.count", 16'(bus.count_o), 16'd1);
        check("t1.drop", 16'(bus.call_drop_o), 16'd0);
        check("t1.req_early", 16'(bus.request_o), 16'd0);
        step();
        check("t1.req", 16'(bus.request_o), 16'd1);
        check("t1.cur", 16'(bus.requested_current_floor_o), 16'd3);
        check("t1.dst", 16'(bus.requested_destination_floor_o), 16'd7);
        check("t1.drop2", 16'(bus.call_drop_o), 16'd0);
        serve();
        check("t1.req_pop", 16'(bus.request_o), 16'd0);
        check("t1.count_pop", 16'(bus.count_o), 16'd0);
        step();
        check("t1.req_idle", 16'(bus.request_o), 16'd0);

        // Ordering with a one-cycle gap between presentations.
        push(4'd2, 4'd5);
        push(4'd6, 4'd1);
        push(4'd4, 4'd9);
        check("t2.count", 16'(bus.count_o), 16'd3);
        check("t2.req0", 16'(bus.request_o), 16'd1);
        check("t2.cur0", 16'(bus.requested_current_floor_o), 16'd2);
        check("t2.dst0", 16'(bus.requested_destination_floor_o), 16'd5);
        serve();
        check("t2.gap0", 16'(bus.request_o), 16'd0);
        check("t2.count1", 16'(bus.count_o), 16'd2);
        step();
        check("t2.req1", 16'(bus.request_o), 16'd1);
        check("t2.cur1", 16'(bus.requested_current_floor_o), 16'd6);
        check("t2.dst1", 16'(bus.requested_destination_floor_o), 16'd1);
        serve();
        check("t2.gap1", 16'(bus.request_o), 16'd0);
        check("t2.hold1", 16'(bus.requested_current_floor_o), 16'd6);
        step();
        check("t2.req2", 16'(bus.request_o), 16'd1);
        check("t2.cur2", 16'(bus.requested_current_floor_o), 16'd4);
        check("t2.dst2", 16'(bus.requested_destination_floor_o), 16'd9);
        serve();
        check("t2.count_end", 16'(bus.count_o), 16'd0);
        step();
        check("t2.idle", 16'(bus.request_o), 16'd0);
        check("t2.hold_dst", 16'(bus.requested_destination_floor_o), 16'd9);

        // Rejections: same floor, out of range, duplicate.
        push(4'd5, 4'd5);
        check("t3.drop_same", 16'(bus.call_drop_o), 16'd1);
        check("t3.count_same", 16'(bus.count_o), 16'd0);
        push(4'd12, 4'd3);
        check("t3.drop_range", 16'(bus.call_drop_o), 16'd1);
        check("t3.count_range", 16'(bus.count_o), 16'd0);
        push(4'd3, 4'd7);
        check("t3.drop_ok", 16'(bus.call_drop_o), 16'd0);
        check("t3.count_ok", 16'(bus.count_o), 16'd1);
        push(4'd3, 4'd7);
        check("t3.drop_dup", 16'(bus.call_drop_o), 16'd1);
        check("t3.count_dup", 16'(bus.count_o), 16'd1);
        step();
        check("t3.drop_pulse", 16'(bus.call_drop_o), 16'd0);
        serve();
        step();
        check("t3.count_end", 16'(bus.count_o), 16'd0);

        // Fill, push-after-pop at full, then drain across the tail wrap.
        for (int i = 1; i <= 8; i++) push(4'(i), 4'(i + 1));
        check("t4.count_full", 16'(bus.count_o), 16'd8);
        check("t4.ready_full", 16'(bus.call_ready_o), 16'd0);
        check("t4.head_cur", 16'(bus.requested_current_floor_o), 16'd1);
        bus.call_valid_i     = 1'b1;
        bus.call_src_floor_i = 4'd9;
        bus.call_dst_floor_i = 4'd0;
        serve();
        check("t4.count_pop", 16'(bus.count_o), 16'd7);
        check("t4.ready_pop", 16'(bus.call_ready_o), 16'd1);
        step();
        bus.call_valid_i = 1'b0;
        check("t4.count_refill", 16'(bus.count_o), 16'd8);
        check("t4.ready_refill", 16'(bus.call_ready_o), 16'd0);
        for (int i = 0; i < 8; i++) begin
            exp_src[i] = 4'(i + 2);
            exp_dst[i] = (i == 7) ? 4'd0 : 4'(i + 3);
        end
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t4.req%0d", i), 16'(bus.request_o), 16'd1);
            check($sformatf("t4.cur%0d", i), 16'(bus.requested_current_floor_o),
                  16'(exp_src[i]));
            check($sformatf("t4.dst%0d", i), 16'(bus.requested_destination_floor_o),
                  16'(exp_dst[i]));
            serve();
            check($sformatf("t4.gap%0d", i), 16'(bus.request_o), 16'd0);
            step();
        end
        check("t4.count_end", 16'(bus.count_o), 16'd0);
        check("t4.idle", 16'(bus.request_o), 16'd0);

        // Watchdog with TIMEOUT=20.
        push(4'd1, 4'd4);
        step();
        check("t5.req", 16'(bus.request_o), 16'd1);
        repeat (19) step();
        check("t5.stall_pre", 16'(bus.stall_o), 16'd0);
        step();
        check("t5.stall_rise", 16'(bus.stall_o), 16'd1);
        repeat (3) step();
        check("t5.stall_hold", 16'(bus.stall_o), 16'd1);
        check("t5.req_hold", 16'(bus.request_o), 16'd1);
        serve();
        check("t5.stall_clear", 16'(bus.stall_o), 16'd0);
        step();

        // Reset mid-queue with a coincident handshake.
        push(4'd1, 4'd2);
        push(4'd2, 4'd3);
        push(4'd3, 4'd4);
        repeat (19) step();
        check("t6.stall_pre", 16'(bus.stall_o), 16'd1);
        check("t6.count_pre", 16'(bus.count_o), 16'd3);
        rst                  = 1'b1;
        bus.call_valid_i     = 1'b1;
        bus.call_src_floor_i = 4'd5;
        bus.call_dst_floor_i = 4'd6;
        step();
        rst              = 1'b0;
        bus.call_valid_i = 1'b0;
        check_reset_outputs("t6");
        step();
        check("t6.count_after", 16'(bus.count_o), 16'd0);
        check("t6.req_after", 16'(bus.request_o), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
